// File: rtl/hamming_minmax.sv
// rtl/hamming_minmax.sv - sequential nibble-serial Hamming distance with running min/max/count
//
// Accepts one operand pair, XORs it, popcounts the XOR one nibble per cycle
// (LSB nibble first) and presents the distance on a valid/ready output.
// Running min/max distance and a saturating pair count are kept across pairs.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous statistics clear (min/max/count only)
//   in_valid/in_ready     operand pair handshake, in_a/in_b operands
//   out_valid/out_ready   result handshake, out_dist distance of current pair
//   min_dist/max_dist     extremes since reset/clear (min=WIDTH means no data)
//   pair_count            delivered pairs since reset/clear, saturates at 255
module hamming_minmax #(
  parameter int  WIDTH = 16,
  localparam int NIBS  = WIDTH / 4,
  localparam int DW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_dist,
  output logic [DW-1:0]    min_dist,
  output logic [DW-1:0]    max_dist,
  output logic [7:0]       pair_count
);

  localparam int NW = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [NW-1:0] LAST_NIB = NW'(NIBS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] x;
  logic [DW-1:0]    acc;
  logic [NW-1:0]    nib;
  logic [2:0]       pc;
  logic [DW-1:0]    acc_next;
  logic             hs;

  function automatic logic [2:0] popcount4(input logic [3:0] n);
    return {2'b00, n[0]} + {2'b00, n[1]} + {2'b00, n[2]} + {2'b00, n[3]};
  endfunction

  // x is shifted right each ACCUM cycle, so the current nibble is always x[3:0]
  assign pc       = popcount4(x[3:0]);
  assign acc_next = acc + DW'(pc);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign hs        = (state == DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x        <= '0;
      acc      <= '0;
      nib      <= '0;
      out_dist <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= in_a ^ in_b;
            acc   <= '0;
            nib   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          x   <= x >> 4;
          nib <= nib + NW'(1);
          if (nib == LAST_NIB) begin
            out_dist <= acc_next;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clear takes priority over folding a coincident result into the statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_dist   <= DW'(WIDTH);
      max_dist   <= '0;
      pair_count <= '0;
    end else if (clear) begin
      min_dist   <= DW'(WIDTH);
      max_dist   <= '0;
      pair_count <= '0;
    end else if (hs) begin
      if (out_dist < min_dist) min_dist <= out_dist;
      if (out_dist > max_dist) max_dist <= out_dist;
      if (pair_count != 8'hFF) pair_count <= pair_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_hamming_minmax.sv
// tb/tb_hamming_minmax.sv - scoreboard bench for hamming_minmax
module tb_hamming_minmax;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        clear = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_a = 0;
  logic [15:0] in_b = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [4:0]  out_dist;
  logic [4:0]  min_dist;
  logic [4:0]  max_dist;
  logic [7:0]  pair_count;

  int n_vec = 0;
  int n_miss = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  hamming_minmax #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
    .min_dist(min_dist), .max_dist(max_dist), .pair_count(pair_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else chk("out_dist", int'(out_dist), exp_q.pop_front());
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input int exp, input bit push);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid = 1; in_a = a; in_b = b;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  // Called just after the acceptance edge; expects out_valid in the 5th cycle
  task automatic wait_out();
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) chk("in_ready_busy", int'(in_ready), 0);
    end while (!out_valid && lat < 20);
    chk("latency", lat, 5);
    chk("in_ready_done", int'(in_ready), 0);
  endtask

  task automatic chk_stats(input string tag, input int mn, input int mx, input int cnt);
    chk({tag, "_min"}, int'(min_dist), mn);
    chk({tag, "_max"}, int'(max_dist), mx);
    chk({tag, "_cnt"}, int'(pair_count), cnt);
  endtask

  initial begin
    logic [15:0] sa [4] = '{16'h1234, 16'hFFFF, 16'hA5A5, 16'h007F};
    logic [15:0] sb [4] = '{16'h0000, 16'h0000, 16'hA5A5, 16'h0000};
    int          sd [4] = '{5, 16, 0, 7};
    int t;

    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_dist", int'(out_dist), 0);
    chk_stats("rst", 16, 0, 0);
    @(posedge clk); #1 rst_n = 1;

    // First pair, exact latency, stats after handshake
    send(16'hFFFF, 16'h0000, 16, 1);
    wait_out();
    @(negedge clk);
    chk("idle_after_hs", int'(in_ready), 1);
    chk_stats("first", 16, 16, 1);

    send(16'hA5A5, 16'hA5A5, 0, 1);
    wait_out();
    send(16'h1234, 16'h0000, 5, 1);
    wait_out();
    @(negedge clk);
    chk_stats("three", 0, 16, 3);

    // Stream 5,16,0,7 from cleared statistics
    @(posedge clk); #1 clear = 1;
    @(posedge clk); #1 clear = 0;
    for (int i = 0; i < 4; i++) begin
      send(sa[i], sb[i], sd[i], 1);
      wait_out();
    end
    @(negedge clk);
    chk_stats("stream", 0, 16, 4);

    // Backpressure: hold out_ready low for 3 DONE cycles
    @(posedge clk); #1 clear = 1; out_ready = 0;
    @(posedge clk); #1 clear = 0;
    send(16'h00FF, 16'h0000, 8, 1);
    wait_out();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = 16'hFFFF; in_b = 16'h0000;
      @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_dist", int'(out_dist), 8);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_cnt", int'(pair_count), 0);
    end
    in_valid = 0;
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk);
    chk("pre_hs_cnt", int'(pair_count), 0);
    @(negedge clk);
    chk_stats("post_stall", 8, 8, 1);
    chk("post_stall_idle", int'(out_valid), 0);

    // clear coinciding with the handshake of a distance-3 pair
    out_ready = 0;
    send(16'h0007, 16'h0000, 3, 1);
    wait_out();
    @(posedge clk); #1 out_ready = 1; clear = 1;
    @(posedge clk); #1 clear = 0;
    @(negedge clk);
    chk_stats("clear_hs", 16, 0, 0);
    chk("clear_hs_idle", int'(in_ready), 1);

    // Saturation: 260 pairs, a = low byte pattern, distance = ones in that byte
    for (int i = 0; i < 260; i++) begin
      logic [15:0] a;
      a = 16'(i & 8'hFF);
      send(a, 16'h0000, $countones(a), 1);
      t = 0;
      while (!out_valid && t < 20) begin @(negedge clk); t++; end
      if (!out_valid) chk("sat_timeout", 0, 1);
    end
    @(negedge clk);
    @(negedge clk);
    chk_stats("sat", 0, 8, 255);

    // Reset during ACCUM aborts the pair
    send(16'hFFFF, 16'h0000, 16, 0);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_dist", int'(out_dist), 0);
    chk_stats("abort", 16, 0, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", int'(out_valid), 0);
    end
    send(16'h1234, 16'h0000, 5, 1);
    wait_out();
    @(negedge clk);
    chk_stats("after_abort", 5, 5, 1);

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hamming_minmax.md
# hamming_minmax

Sequential Hamming-distance engine for the pairwise-distance datapath. It accepts one pair of WIDTH-bit operands per transaction and XORs them. It then population-counts the XOR result one nibble per cycle, accumulates the distance and returns it on a valid/ready output. Running minimum and maximum distances and a pair count are kept across transactions for the min/max-distance program. The block sits downstream of operand fetch and upstream of the register write-back.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 4.
- NIBS, WIDTH/4, derived; number of nibble cycles per pair.
- DW, $clog2(WIDTH+1), derived; distance width (5 for WIDTH=16).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous statistics clear: min/max/count only.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  distance result valid.
- out_ready  in  1  consumer accepts result.
- out_dist  out  DW  Hamming distance of the current pair.
- min_dist  out  DW  smallest distance delivered since reset/clear.
- max_dist  out  DW  largest distance delivered since reset/clear.
- pair_count  out  8  delivered pairs since reset/clear, saturating at 255.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch x=in_a^in_b, acc=0, nib=0, go to ACCUM.
  - ACCUM: each cycle acc += popcount(x[4*nib+3:4*nib]), nibble 0 (LSBs) first, then nib++. After nibble NIBS-1 is added, go to DONE.
  - DONE: out_valid=1, out_dist=acc held stable. On out_valid&&out_ready, update statistics and go to IDLE.
- in_ready=0 in ACCUM and DONE; in_valid there is ignored and the inputs are not sampled.
- Nibble popcount is combinational: 0→0; one bit set→1; two set→2; three set→3; 0xF→4. acc never exceeds WIDTH, so DW bits never overflow.
- Statistics update on each output handshake:
  - min_dist = min(min_dist, out_dist).
  - max_dist = max(max_dist, out_dist).
  - pair_count = pair_count+1, saturating at 255.
- Equal distances leave min/max unchanged in value.
- clear: min_dist←WIDTH, max_dist←0, pair_count←0.
  - clear has no effect on the FSM or on an in-flight pair.
  - If clear coincides with an output handshake, clear wins and that result is not folded into the statistics. The FSM still returns to IDLE.
- Before the first pair, min_dist=WIDTH is the "no data" value; consumers gate on pair_count≠0.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_dist=0, min_dist=WIDTH, max_dist=0, pair_count=0, acc=0, nib=0, x=0.
- The reset assertion in any state aborts the in-flight pair immediately; no result is produced.
- The pair is accepted on the edge at cycle T (in_valid&&in_ready).
- ACCUM occupies cycles T+1..T+NIBS.
- out_valid rises at cycle T+NIBS+1 (T+5 for WIDTH=16).
- Output handshake at cycle H: statistics are visible from H+1, and in_ready=1 from H+1.
- Best-case throughput is one pair per NIBS+2 cycles; there is no input/output overlap.
- Backpressure: out_valid and out_dist hold indefinitely while out_ready=0. No input is accepted meanwhile.
- All outputs are registered, except in_ready and out_valid, which are decoded from the state register only. There is no combinational path from any input.

## Test plan
- Reset, then a=0xFFFF, b=0x0000 → out_valid exactly 5 cycles after acceptance, out_dist=16. After the handshake: min=16, max=16, count=1.
- a=0xA5A5, b=0xA5A5 → out_dist=0. a=0x1234, b=0x0000 → out_dist=5.
- Stream of pairs with distances 5, 16, 0, 7, with out_ready=1 → min_dist=0, max_dist=16, pair_count=4 after the last handshake. in_ready is low during every ACCUM/DONE cycle.
- Hold out_ready=0 for 3 cycles in DONE → out_dist stable and in_ready=0 throughout. in_valid pulses during the stall are ignored. Statistics change only on the cycle after out_ready rises.
- Assert clear on the same cycle as the handshake of a pair with distance 3 → min=16, max=0, count=0 afterwards. Then run 256+ pairs → pair_count saturates at 255.
- Deassert rst_n during ACCUM (cycle T+2) → all outputs return to their reset values. No out_valid follows, and the next pair computes correctly from IDLE.
